// File: rtl/audio_pkg.sv
// Shared types and constants for the stereo sample buffer feeding i2s_driver.
package audio_pkg;

  localparam int WIDTH_DEFAULT      = 16;
  localparam int DEPTH_LOG2_DEFAULT = 3;

  // Value driven to the driver while prefilling or after an underrun.
  localparam logic MUTE_BIT = 1'b0;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fifo_state_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// Stereo-pair register array: one synchronous write port, one combinational read port.
module sample_fifo_mem
  import audio_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [2*WIDTH-1:0]    wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [2*WIDTH-1:0]    rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [2*WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the level counter, so stale
  // entries are never observed and the array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO with prefill gating, underrun muting and one pop per I2S frame strobe.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [WIDTH-1:0]      IN_L,
  input  logic [WIDTH-1:0]      IN_R,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  LATCH,
  output logic [WIDTH-1:0]      DATA_L,
  output logic [WIDTH-1:0]      DATA_R,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  UNDERRUN,
  input  logic                  CLR_ERR
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_HALF = (DEPTH_LOG2+1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  fifo_state_t           state_q, state_d;
  logic                  latch_q;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [2*WIDTH-1:0]    head;
  logic                  frame, push, pop, underrun_evt;

  assign frame        = LATCH & ~latch_q;
  assign push         = IN_VALID & IN_READY;
  assign pop          = frame & (state_q == RUN) & (level_q != '0);
  assign underrun_evt = frame & (state_q == RUN) & (level_q == '0);

  // Ready comes from registered occupancy only; a pop while full frees a slot next cycle.
  assign IN_READY = (level_q != LVL_FULL);
  assign LEVEL    = level_q;

  sample_fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({IN_L, IN_R}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Leaving FILL uses the post-edge level so RUN starts on the edge that reaches half full.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (level_d >= LVL_HALF) state_d = RUN;
      RUN:  if (underrun_evt)        state_d = FILL;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= FILL;
      latch_q  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      DATA_L   <= {WIDTH{MUTE_BIT}};
      DATA_R   <= {WIDTH{MUTE_BIT}};
      UNDERRUN <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= LATCH;
      level_q <= level_d;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (frame) begin
        DATA_L <= pop ? head[2*WIDTH-1:WIDTH] : {WIDTH{MUTE_BIT}};
        DATA_R <= pop ? head[WIDTH-1:0]       : {WIDTH{MUTE_BIT}};
      end
      if (underrun_evt)  UNDERRUN <= 1'b1;
      else if (CLR_ERR)  UNDERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Scoreboard bench for audio_sample_fifo: prefill, back-pressure, underrun, held LATCH, wrap, reset.
module tb_audio_sample_fifo;

  localparam int WIDTH      = 16;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 8;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic [WIDTH-1:0]    IN_L = '0, IN_R = '0;
  logic                IN_VALID = 1'b0, LATCH = 1'b0, CLR_ERR = 1'b0;
  logic                IN_READY, UNDERRUN;
  logic [WIDTH-1:0]    DATA_L, DATA_R;
  logic [DEPTH_LOG2:0] LEVEL;

  always #5 CLK = ~CLK;

  audio_sample_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_L(IN_L), .IN_R(IN_R), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .LATCH(LATCH), .DATA_L(DATA_L), .DATA_R(DATA_R),
    .LEVEL(LEVEL), .UNDERRUN(UNDERRUN), .CLR_ERR(CLR_ERR)
  );

  // Scoreboard: pairs expected to be stored, in push order, plus expected output state.
  logic [2*WIDTH-1:0] sb[$];
  int                 vectors = 0, miscompares = 0, popped = 0;
  bit                 running = 0, latch_prev = 0, exp_underrun = 0;
  logic [WIDTH-1:0]   exp_l = '0, exp_r = '0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    running = 0; latch_prev = 0; exp_underrun = 0;
    exp_l = '0; exp_r = '0;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    IN_VALID = 1'b0; LATCH = 1'b0; CLR_ERR = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // One clock of stimulus; expected outputs come from the scoreboard and are compared after the edge.
  task automatic cycle(input bit valid, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                       input bit latch, input bit clr);
    bit accept, frame, went_fill;
    IN_VALID = valid; IN_L = l; IN_R = r; LATCH = latch; CLR_ERR = clr;
    accept    = valid && (sb.size() < DEPTH);
    frame     = latch && !latch_prev;
    went_fill = 0;
    if (frame) begin
      if (running && sb.size() > 0) begin
        {exp_l, exp_r} = sb.pop_front();
        popped++;
      end else begin
        exp_l = '0; exp_r = '0;
        went_fill = running;
      end
    end
    if (accept) sb.push_back({l, r});
    if (went_fill) begin
      running = 0; exp_underrun = 1;
    end else begin
      if (clr) exp_underrun = 0;
      if (!running && sb.size() >= DEPTH / 2) running = 1;
    end
    latch_prev = latch;
    tick();
    IN_VALID = 1'b0; LATCH = 1'b0; CLR_ERR = 1'b0;
    vectors++;
    if (DATA_L !== exp_l || DATA_R !== exp_r) begin
      miscompares++;
      $display("FAIL sb_data @%0t: got %h/%h expected %h/%h", $time, DATA_L, DATA_R, exp_l, exp_r);
    end
    vectors++;
    if (LEVEL !== (DEPTH_LOG2+1)'(sb.size())) begin
      miscompares++;
      $display("FAIL sb_level @%0t: got %0d expected %0d", $time, LEVEL, sb.size());
    end
    vectors++;
    if (UNDERRUN !== exp_underrun || IN_READY !== (sb.size() < DEPTH)) begin
      miscompares++;
      $display("FAIL sb_flags @%0t: got underrun=%b ready=%b expected underrun=%b ready=%b",
               $time, UNDERRUN, IN_READY, exp_underrun, sb.size() < DEPTH);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #3;
    vectors++;
    if (DATA_L !== 16'h0 || DATA_R !== 16'h0 || LEVEL !== 4'd0 || UNDERRUN !== 1'b0 || IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got %h/%h level=%0d underrun=%b ready=%b expected 0000/0000 level=0 underrun=0 ready=1",
               DATA_L, DATA_R, LEVEL, UNDERRUN, IN_READY);
    end
    apply_reset();
  endtask

  task automatic test_prefill();
    apply_reset();
    cycle(1, 16'h0AA0, 16'hA00A, 0, 0);
    cycle(1, 16'h0BB0, 16'hB00B, 0, 0);
    cycle(1, 16'h0CC0, 16'hC00C, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, (i % 2) == 0, 0);
    vectors++;
    if (DATA_L !== 16'h0 || DATA_R !== 16'h0 || UNDERRUN !== 1'b0 || LEVEL !== 4'd3) begin
      miscompares++;
      $display("FAIL prefill_gate: got %h/%h underrun=%b level=%0d expected 0000/0000 underrun=0 level=3",
               DATA_L, DATA_R, UNDERRUN, LEVEL);
    end
    cycle(1, 16'h0DD0, 16'hD00D, 0, 0);
    cycle(0, '0, '0, 1, 0);
    vectors++;
    if (DATA_L !== 16'h0AA0 || DATA_R !== 16'hA00A || LEVEL !== 4'd3) begin
      miscompares++;
      $display("FAIL prefill_first: got %h/%h level=%0d expected 0aa0/a00a level=3", DATA_L, DATA_R, LEVEL);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 0, 0);
    vectors++;
    if (IN_READY !== 1'b0 || LEVEL !== 4'd8) begin
      miscompares++;
      $display("FAIL full_ready: got ready=%b level=%0d expected ready=0 level=8", IN_READY, LEVEL);
    end
    cycle(1, 16'h1008, 16'h2008, 0, 0);
    cycle(1, 16'h1008, 16'h2008, 0, 0);
    cycle(1, 16'h1008, 16'h2008, 1, 0);
    vectors++;
    if (LEVEL !== 4'd7 || IN_READY !== 1'b1 || DATA_L !== 16'h1000) begin
      miscompares++;
      $display("FAIL full_pop: got level=%0d ready=%b data_l=%h expected level=7 ready=1 data_l=1000",
               LEVEL, IN_READY, DATA_L);
    end
    cycle(1, 16'h1008, 16'h2008, 0, 0);
    vectors++;
    if (LEVEL !== 4'd8) begin
      miscompares++;
      $display("FAIL full_ninth: got level=%0d expected 8", LEVEL);
    end
  endtask

  // Continues from the full FIFO left by test_full.
  task automatic test_underrun();
    for (int i = 0; i < 16; i++) cycle(0, '0, '0, (i % 2) == 0, 0);
    cycle(0, '0, '0, 1, 0);
    vectors++;
    if (DATA_L !== 16'h0 || DATA_R !== 16'h0 || UNDERRUN !== 1'b1 || LEVEL !== 4'd0) begin
      miscompares++;
      $display("FAIL underrun_set: got %h/%h underrun=%b level=%0d expected 0000/0000 underrun=1 level=0",
               DATA_L, DATA_R, UNDERRUN, LEVEL);
    end
    cycle(0, '0, '0, 0, 1);
    vectors++;
    if (UNDERRUN !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun_clear: got %b expected 0", UNDERRUN);
    end
    cycle(1, 16'h1234, 16'h5678, 0, 0);
    cycle(0, '0, '0, 1, 0);
    vectors++;
    if (DATA_L !== 16'h0 || LEVEL !== 4'd1 || UNDERRUN !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun_fill: got data_l=%h level=%0d underrun=%b expected data_l=0000 level=1 underrun=0",
               DATA_L, LEVEL, UNDERRUN);
    end
  endtask

  task automatic test_latch_held();
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1, 16'h3000 + 16'(i), 16'h4000 + 16'(i), 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 0, 0);
    vectors++;
    if (LEVEL !== 4'd4 || DATA_L !== 16'h3000 || DATA_R !== 16'h4000) begin
      miscompares++;
      $display("FAIL latch_held: got level=%0d %h/%h expected level=4 3000/4000", LEVEL, DATA_L, DATA_R);
    end
  endtask

  task automatic test_wrap();
    int k, cyc, start;
    apply_reset();
    k = 0; cyc = 0; start = popped;
    while (k < 20 && cyc < 300) begin
      bit will_accept;
      will_accept = sb.size() < DEPTH;
      cycle(1, 16'h5000 + 16'(k), 16'h6000 + 16'(k), (cyc % 3) == 0, 0);
      if (will_accept) k++;
      cyc++;
    end
    while (sb.size() > 0 && cyc < 600) begin
      cycle(0, '0, '0, (cyc % 2) == 0, 0);
      cyc++;
    end
    vectors++;
    if (popped - start != 20 || UNDERRUN !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d pops underrun=%b expected 20 pops underrun=0", popped - start, UNDERRUN);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 6; i++) cycle(1, 16'h7000 + 16'(i), 16'h8000 + 16'(i), 0, 0);
    cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 0, 0);
    vectors++;
    if (LEVEL !== 4'd5 || DATA_L !== 16'h7000) begin
      miscompares++;
      $display("FAIL midreset_pre: got level=%0d data_l=%h expected level=5 data_l=7000", LEVEL, DATA_L);
    end
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (DATA_L !== 16'h0 || DATA_R !== 16'h0 || LEVEL !== 4'd0 || IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_async: got %h/%h level=%0d ready=%b expected 0000/0000 level=0 ready=1",
               DATA_L, DATA_R, LEVEL, IN_READY);
    end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    cycle(1, 16'h9999, 16'hAAAA, 0, 0);
    cycle(0, '0, '0, 1, 0);
    vectors++;
    if (DATA_L !== 16'h0 || LEVEL !== 4'd1) begin
      miscompares++;
      $display("FAIL midreset_fill: got data_l=%h level=%0d expected data_l=0000 level=1", DATA_L, LEVEL);
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_full();
    test_underrun();
    test_latch_held();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Stereo sample buffer feeding `i2s_driver`. Accepts demodulated left/right audio words from the DSP chain over a valid/ready handshake and stores them in a small FIFO. Presents one held sample pair on `DATA_L`/`DATA_R`, advancing once per I2S frame on the driver's `LATCH` strobe. Provides start-up prefill, underrun muting and occupancy status, so rate jitter between the DSP clock-enable and the I2S frame rate is absorbed here rather than in the driver.

## Interface
- `WIDTH`, 16, sample word width per channel (matches `i2s_driver` `DATA_L`/`DATA_R`)
- `DEPTH_LOG2`, 3, log2 of FIFO depth in stereo pairs (default depth 8)
- `CLK`  in  1  system clock, shared with `i2s_driver`
- `RST_N`  in  1  reset, asynchronous, active-low
- `IN_L`  in  WIDTH  left sample from DSP
- `IN_R`  in  WIDTH  right sample from DSP
- `IN_VALID`  in  1  `IN_L`/`IN_R` valid
- `IN_READY`  out  1  FIFO can accept a pair this cycle
- `LATCH`  in  1  from `i2s_driver`; rising edge means the current `DATA_L`/`DATA_R` have been captured
- `DATA_L`  out  WIDTH  left sample to `i2s_driver`
- `DATA_R`  out  WIDTH  right sample to `i2s_driver`
- `LEVEL`  out  DEPTH_LOG2+1  pairs currently stored, 0..2^DEPTH_LOG2
- `UNDERRUN`  out  1  sticky; set on a RUN-state pop from an empty FIFO
- `CLR_ERR`  in  1  synchronous clear of `UNDERRUN`

## Operation
- **Push.** Occurs when `IN_VALID && IN_READY`. `IN_READY = (LEVEL != DEPTH)`, taken from registered state only, with no full-bypass. A pop in the same cycle as a full FIFO does not raise `IN_READY` until the next cycle.
- **Frame strobe.** `frame = LATCH & ~latch_q`, where `latch_q` is `LATCH` registered. A level held high yields exactly one strobe.
- **State FILL** (reset state):
  - On `frame`, load `DATA_L`/`DATA_R` with 0 (mute) without popping.
  - Go to RUN when `LEVEL >= DEPTH/2` at a clock edge.
- **State RUN:**
  - On `frame` with `LEVEL > 0`, pop the head into `DATA_L`/`DATA_R`.
  - On `frame` with `LEVEL == 0`, load 0, set `UNDERRUN`, and return to FILL.
- **Simultaneous push and pop.** `LEVEL` is unchanged. Pointers both advance modulo DEPTH.
- **Push and frame when empty in RUN.** Counts as an underrun. The pushed pair is stored and the state goes to FILL.
- **Counters.** Read/write pointers are DEPTH_LOG2 bits and wrap naturally. `LEVEL` is tracked as a separate counter, never derived from pointer difference.
- **Error flag.** `CLR_ERR` clears `UNDERRUN`. If `CLR_ERR` and a new underrun occur in the same cycle, set wins.
- **Reset** (async assert, sync release by the system reset tree):
  - `DATA_L = DATA_R = 0`, `LEVEL = 0`, `UNDERRUN = 0`, `IN_READY = 1`.
  - State is FILL and pointers are 0. Memory contents are not reset.
- **Reset mid-operation.** All stored pairs are discarded and the output is muted until prefill completes again.

## Timing
- **Push to storage.** A pair pushed at edge n is counted in `LEVEL` after edge n.
- **Strobe to output.** If `LATCH` rises in the cycle before edge n, `DATA_L`/`DATA_R` show the new pair after edge n (1-cycle latency). The outputs are then held constant until the next `frame`.
- **Driver capture window.** `i2s_driver` captures on `LATCH`, so the update lands in the following frame. Outputs never change outside a `frame` cycle, except at reset.
- **Prefill to first sample.** FILL→RUN takes effect on the edge where `LEVEL` reaches DEPTH/2. The first non-zero sample appears on the next `frame` after that.
- **Throughput.** One push per cycle is sustainable. The pop rate is bounded by the frame rate.

## Structure
- **Package `audio_pkg`:** `WIDTH` default, a 2-state enum `fifo_state_t` {FILL, RUN}, and the mute value constant (0).
- **Sub-module `sample_fifo_mem`:** a 2^DEPTH_LOG2 × (2·WIDTH) register array with one synchronous write port and a combinational read port addressed by the read pointer.
- **Top level:** all control (pointers, level, FSM, edge detect, output registers) lives in `audio_sample_fifo`.

## Test plan
- **Prefill gating.** After reset, push 3 pairs (0x0AA0/0xA00A, …) and pulse `LATCH` twice. Required: `DATA_L`/`DATA_R` stay 0, `UNDERRUN` stays 0, `LEVEL` = 3. Push a 4th pair; the next `LATCH` gives `DATA_L` = 0x0AA0, `DATA_R` = 0xA00A, and `LEVEL` = 3.
- **Full back-pressure.** Push 9 pairs continuously with no `LATCH`. Required: `IN_READY` drops after the 8th accept, `LEVEL` = 8, and the 9th pair is stored only after the next `frame`.
- **Underrun.** In RUN, drain to empty and pulse `LATCH` once more. Required: outputs = 0, `UNDERRUN` = 1, state returns to FILL. `CLR_ERR` then clears `UNDERRUN`.
- **Level-held LATCH.** Hold `LATCH` high for 5 cycles. Required: exactly one pop and `LEVEL` decrements by 1.
- **Wrap-around.** Stream 20 distinct pairs with a push every cycle and `LATCH` every 3 cycles. Required: outputs appear in push order with no loss or duplication across pointer wrap.
- **Reset mid-stream.** Assert `RST_N` low asynchronously between edges with `LEVEL` = 5. Required: outputs immediately 0, `LEVEL` = 0, `IN_READY` = 1, state FILL.
